// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard detector with a 3-slot destination scoreboard, stall/flush
// generation and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int FWD_EN       = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  src1_id,
  input  logic [4:0]  src2_id,
  input  logic        two_src_id,
  input  logic [4:0]  dest_id,
  input  logic        WB_En_id,
  input  logic        MEM_R_En_id,
  input  logic        Br_taken,
  output logic        stall,
  output logic        Flush,
  output logic [1:0]  state,
  output logic [15:0] hazard_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  typedef struct packed {
    logic       wb;
    logic       load;
    logic [4:0] dest;
  } slot_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  slot_t       r_sb_ex;
  slot_t       r_sb_mem;
  slot_t       r_sb_wb;
  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_fcnt;
  logic [2:0]  w_fcnt_next;
  logic [15:0] r_hcnt;
  logic        w_ex_hit;
  logic        w_mem_hit;
  logic        w_hazard;
  logic        w_unused;

  function automatic logic f_match(input slot_t slot, input logic [4:0] src);
    return slot.wb & (slot.dest != 5'd0) & (slot.dest == src);
  endfunction

  assign w_ex_hit  = f_match(r_sb_ex, src1_id)  | (two_src_id & f_match(r_sb_ex, src2_id));
  assign w_mem_hit = f_match(r_sb_mem, src1_id) | (two_src_id & f_match(r_sb_mem, src2_id));

  // With forwarding only a load still in EX cannot supply its result in time.
  generate
    if (FWD_EN != 0) begin : g_fwd
      assign w_hazard = r_sb_ex.load & w_ex_hit;
    end else begin : g_nofwd
      assign w_hazard = w_ex_hit | w_mem_hit;
    end
  endgenerate

  // The WB slot is tracked for visibility only; the register file resolves it.
  assign w_unused = ^{r_sb_wb, r_sb_mem.load, w_mem_hit};

  assign Flush      = (Br_taken | (r_state == ST_FLUSH)) & ~rst;
  assign stall      = w_hazard & ~Flush & ~rst;
  assign state      = r_state;
  assign hazard_cnt = r_hcnt;

  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    case (r_state)
      ST_RUN, ST_STALL: begin
        if (Br_taken && (FLUSH_CYCLES > 1)) begin
          w_state_next = ST_FLUSH;
          w_fcnt_next  = FLUSH_RELOAD;
        end else if (stall) begin
          w_state_next = ST_STALL;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_fcnt_next = (r_fcnt != 3'd0) ? r_fcnt - 3'd1 : 3'd0;
        if (r_fcnt <= 3'd1) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_fcnt_next  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_ex  <= '0;
      r_sb_mem <= '0;
      r_sb_wb  <= '0;
      r_state  <= ST_RUN;
      r_fcnt   <= 3'd0;
      r_hcnt   <= 16'd0;
    end else begin
      r_sb_wb  <= r_sb_mem;
      r_sb_mem <= r_sb_ex;
      if (stall || Flush) begin
        r_sb_ex <= '0;
      end else begin
        r_sb_ex <= '{wb: WB_En_id, load: MEM_R_En_id, dest: dest_id};
      end
      r_state <= w_state_next;
      r_fcnt  <= w_fcnt_next;
      if (stall && (r_hcnt != 16'hFFFF)) begin
        r_hcnt <= r_hcnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: the driver queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the selected instance.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  src1_id = '0;
  logic [4:0]  src2_id = '0;
  logic        two_src_id = 1'b0;
  logic [4:0]  dest_id = '0;
  logic        WB_En_id = 1'b0;
  logic        MEM_R_En_id = 1'b0;
  logic        Br_taken = 1'b0;

  logic        f_stall, f_flush, n_stall, n_flush;
  logic [1:0]  f_state, n_state;
  logic [15:0] f_cnt, n_cnt;

  int vec_cnt = 0;
  int miss_cnt = 0;

  typedef struct {
    int          sel;
    string       name;
    logic        st;
    logic        fl;
    logic [1:0]  s;
    logic [15:0] c;
    bit          chk_reg;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.FWD_EN(1), .FLUSH_CYCLES(3)) dut_f (
    .clk(clk), .rst(rst), .src1_id(src1_id), .src2_id(src2_id),
    .two_src_id(two_src_id), .dest_id(dest_id), .WB_En_id(WB_En_id),
    .MEM_R_En_id(MEM_R_En_id), .Br_taken(Br_taken),
    .stall(f_stall), .Flush(f_flush), .state(f_state), .hazard_cnt(f_cnt)
  );

  hazard_stall_ctrl #(.FWD_EN(0), .FLUSH_CYCLES(1)) dut_n (
    .clk(clk), .rst(rst), .src1_id(src1_id), .src2_id(src2_id),
    .two_src_id(two_src_id), .dest_id(dest_id), .WB_En_id(WB_En_id),
    .MEM_R_En_id(MEM_R_En_id), .Br_taken(Br_taken),
    .stall(n_stall), .Flush(n_flush), .state(n_state), .hazard_cnt(n_cnt)
  );

  task automatic cyc(input bit r, input logic [4:0] s1, input logic [4:0] s2,
                     input bit two, input logic [4:0] d, input bit wb,
                     input bit ld, input bit br);
    @(posedge clk);
    #1;
    rst = r; src1_id = s1; src2_id = s2; two_src_id = two;
    dest_id = d; WB_En_id = wb; MEM_R_En_id = ld; Br_taken = br;
  endtask

  task automatic expect_out(input int sel, input string name, input logic st,
                            input logic fl, input logic [1:0] s,
                            input logic [15:0] c, input bit chk);
    exp_t e;
    e.sel = sel; e.name = name; e.st = st; e.fl = fl; e.s = s; e.c = c;
    e.chk_reg = chk;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic        a_st, a_fl;
      logic [1:0]  a_s;
      logic [15:0] a_c;
      bit          bad;
      e = exp_q.pop_front();
      a_st = (e.sel == 0) ? f_stall : n_stall;
      a_fl = (e.sel == 0) ? f_flush : n_flush;
      a_s  = (e.sel == 0) ? f_state : n_state;
      a_c  = (e.sel == 0) ? f_cnt   : n_cnt;
      bad  = (a_st !== e.st) || (a_fl !== e.fl);
      if (e.chk_reg) bad = bad || (a_s !== e.s) || (a_c !== e.c);
      vec_cnt++;
      if (bad) begin
        miss_cnt++;
        $display("FAIL %s: got stall=%b flush=%b state=%b cnt=%h, want stall=%b flush=%b state=%b cnt=%h",
                 e.name, a_st, a_fl, a_s, a_c, e.st, e.fl, e.s, e.c);
      end else begin
        $display("ok   %s: stall=%b flush=%b state=%b cnt=%h", e.name, a_st, a_fl, a_s, a_c);
      end
    end
  end

  task automatic idle(input bit r);
    cyc(r, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with a branch request present: outputs must stay low.
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1); expect_out(0, "rst_gate", 0, 0, 2'b00, 16'd0, 0);
    idle(0);                               expect_out(0, "rst_state", 0, 0, 2'b00, 16'd0, 1);

    // Load-use with forwarding: one stall cycle.
    cyc(0, 5'd0, 5'd0, 0, 5'd5, 1, 1, 0); expect_out(0, "lu_load", 0, 0, 2'b00, 16'd0, 1);
    cyc(0, 5'd5, 5'd0, 0, 5'd6, 1, 0, 0); expect_out(0, "lu_use", 1, 0, 2'b00, 16'd0, 1);
    cyc(0, 5'd5, 5'd0, 0, 5'd6, 1, 0, 0); expect_out(0, "lu_held", 0, 0, 2'b01, 16'd1, 1);
    idle(0);                               expect_out(0, "lu_after", 0, 0, 2'b00, 16'd1, 1);

    // Register 0 never hazards.
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0); expect_out(0, "r0_load", 0, 0, 2'b00, 16'd1, 1);
    cyc(0, 5'd0, 5'd0, 1, 5'd3, 1, 0, 0); expect_out(0, "r0_use", 0, 0, 2'b00, 16'd1, 1);
    idle(0);                               expect_out(0, "r0_after", 0, 0, 2'b00, 16'd1, 1);

    // Branch with FLUSH_CYCLES=3, concurrent load-use, re-branch during FLUSH.
    idle(1);                               expect_out(0, "br_rst", 0, 0, 2'b00, 16'd1, 1);
    cyc(0, 5'd0, 5'd0, 0, 5'd5, 1, 1, 0); expect_out(0, "br_load", 0, 0, 2'b00, 16'd0, 1);
    cyc(0, 5'd5, 5'd0, 0, 5'd6, 1, 0, 1); expect_out(0, "br_flush1", 0, 1, 2'b00, 16'd0, 1);
    cyc(0, 5'd5, 5'd0, 0, 5'd6, 1, 0, 0); expect_out(0, "br_flush2", 0, 1, 2'b10, 16'd0, 1);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1); expect_out(0, "br_flush3", 0, 1, 2'b10, 16'd0, 1);
    idle(0);                               expect_out(0, "br_done", 0, 0, 2'b00, 16'd0, 1);

    // Reset in the second flush cycle aborts the flush and clears the count.
    cyc(0, 5'd0, 5'd0, 0, 5'd5, 1, 1, 0); expect_out(0, "rf_load", 0, 0, 2'b00, 16'd0, 1);
    cyc(0, 5'd5, 5'd0, 0, 5'd6, 1, 0, 0); expect_out(0, "rf_use", 1, 0, 2'b00, 16'd0, 1);
    cyc(0, 5'd5, 5'd0, 0, 5'd6, 1, 0, 0); expect_out(0, "rf_held", 0, 0, 2'b01, 16'd1, 1);
    cyc(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1); expect_out(0, "rf_flush1", 0, 1, 2'b00, 16'd1, 1);
    cyc(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1); expect_out(0, "rf_rst", 0, 0, 2'b10, 16'd1, 1);
    idle(0);                               expect_out(0, "rf_post1", 0, 0, 2'b00, 16'd0, 1);
    idle(0);                               expect_out(0, "rf_post2", 0, 0, 2'b00, 16'd0, 1);

    // No forwarding: EX and MEM both hazard; src2 ignored when two_src_id=0.
    idle(1);                               expect_out(1, "nf_rst", 0, 0, 2'b00, 16'd0, 0);
    cyc(0, 5'd0, 5'd0, 0, 5'd7, 1, 0, 0); expect_out(1, "nf_alu", 0, 0, 2'b00, 16'd0, 1);
    cyc(0, 5'd3, 5'd7, 1, 5'd0, 0, 0, 0); expect_out(1, "nf_ex", 1, 0, 2'b00, 16'd0, 1);
    cyc(0, 5'd3, 5'd7, 1, 5'd0, 0, 0, 0); expect_out(1, "nf_mem", 1, 0, 2'b01, 16'd1, 1);
    cyc(0, 5'd3, 5'd7, 1, 5'd0, 0, 0, 0); expect_out(1, "nf_wb", 0, 0, 2'b01, 16'd2, 1);
    idle(0);                               expect_out(1, "nf_idle", 0, 0, 2'b00, 16'd2, 1);
    cyc(0, 5'd0, 5'd0, 0, 5'd7, 1, 0, 0); expect_out(1, "n1_alu", 0, 0, 2'b00, 16'd2, 1);
    cyc(0, 5'd3, 5'd7, 0, 5'd0, 0, 0, 0); expect_out(1, "n1_ex", 0, 0, 2'b00, 16'd2, 1);
    cyc(0, 5'd3, 5'd7, 0, 5'd0, 0, 0, 0); expect_out(1, "n1_mem", 0, 0, 2'b00, 16'd2, 1);

    // FLUSH_CYCLES=1: single-cycle flush beats a hazard, MEM hazard follows.
    cyc(0, 5'd0, 5'd0, 0, 5'd9, 1, 0, 0); expect_out(1, "n2_alu", 0, 0, 2'b00, 16'd2, 1);
    cyc(0, 5'd9, 5'd0, 0, 5'd0, 0, 0, 1); expect_out(1, "n2_brhz", 0, 1, 2'b00, 16'd2, 1);
    cyc(0, 5'd9, 5'd0, 0, 5'd0, 0, 0, 0); expect_out(1, "n2_mem", 1, 0, 2'b00, 16'd2, 1);
    idle(0);                               expect_out(1, "n2_idle", 0, 0, 2'b01, 16'd3, 1);
    idle(0);                               expect_out(1, "n2_run", 0, 0, 2'b00, 16'd3, 1);

    // Saturation: an r7<-r7 instruction held in ID stalls 2 of every 3 cycles.
    idle(1);
    for (int i = 0; i <= 98312; i++) begin
      cyc(0, 5'd7, 5'd0, 0, 5'd7, 1, 0, 0);
      case (i)
        0:     expect_out(1, "sat_c0", 0, 0, 2'b00, 16'd0, 1);
        1:     expect_out(1, "sat_c1", 1, 0, 2'b00, 16'd0, 1);
        2:     expect_out(1, "sat_c2", 1, 0, 2'b01, 16'd1, 1);
        30:    expect_out(1, "sat_c30", 0, 0, 2'b01, 16'd20, 1);
        31:    expect_out(1, "sat_c31", 1, 0, 2'b00, 16'd20, 1);
        98310: expect_out(1, "sat_top", 0, 0, 2'b01, 16'hFFFF, 1);
        98311: expect_out(1, "sat_hold1", 1, 0, 2'b00, 16'hFFFF, 1);
        98312: expect_out(1, "sat_hold2", 1, 0, 2'b01, 16'hFFFF, 1);
        default: ;
      endcase
    end

    idle(0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
